debounce_sync: RTL
==================

Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, possibly bouncy 1-bit input into a clean, clock-synchronous level for the D input of the downstream d_ff stage.
- Resynchronises through a 2-flop synchroniser.
- Accepts a new level only after it has been stable for STABLE_CYCLES consecutive samples.
- Emits single-cycle rise/fall pulses for edge-driven consumers.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples required to accept a new level; legal range >= 2.
- CNT_W, $clog2(STABLE_CYCLES+1), width of the stability counter; derived, not overridden.

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- n_res  input  1  reset, asynchronous assert, active-low.
- din  input  1  raw asynchronous input; may glitch at any time.
- Q  output  1  debounced, synchronised level; feeds d_ff D.
- rise  output  1  one-cycle pulse, high in the cycle Q goes 0->1.
- fall  output  1  one-cycle pulse, high in the cycle Q goes 1->0.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (n_res=0, asynchronous):
  - sync1=sync2=0, state=S_LOW, cnt=0, Q=0, rise=0, fall=0, busy=0.
  - Held while n_res=0; normal operation resumes on the first posedge after release.
- Synchroniser: sync1<=din, sync2<=sync1 each posedge. The FSM reads only sync2; din never reaches logic directly.
- FSM states: S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT.
- S_LOW:
  - sync2=1 -> S_RISE_WAIT, cnt<=1.
  - Otherwise stay, cnt<=0.
- S_RISE_WAIT:
  - sync2=0 -> S_LOW, cnt<=0 (glitch rejected, no pulse).
  - sync2=1 and cnt==STABLE_CYCLES-1 -> S_HIGH, Q<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- S_HIGH: mirror of S_LOW on sync2=0 -> S_FALL_WAIT, cnt<=1.
- S_FALL_WAIT: mirror of S_RISE_WAIT; on qualification -> S_LOW, Q<=0, fall<=1.
- rise and fall are registered and default to 0 every cycle. They are never both high. Each lasts exactly one cycle.
- busy = (state==S_RISE_WAIT) || (state==S_FALL_WAIT), decoded from the registered state.
- Latency: din stable from before posedge E0 gives Q changing at posedge E0+STABLE_CYCLES+1 (5 edges for the default).
- Pulse shorter than STABLE_CYCLES samples at sync2: Q, rise and fall unchanged; busy pulses only.
- Bounce restarts qualification: any disagreeing sample during a WAIT state returns to the stable state. Counting then restarts from 1 on the next agreeing sample. There is no accumulated credit.
- Reset mid-qualification: state aborts to S_LOW and Q=0 immediately (asynchronous), even if Q was 1.
- cnt never exceeds STABLE_CYCLES-1, so no wrap-around.
- If din is held high through reset release, Q rises STABLE_CYCLES+1 edges after release via the normal path. There is no shortcut.

Decomposition:
- Package debounce_pkg:
  - enum typedef state_t {S_LOW, S_RISE_WAIT, S_HIGH, S_FALL_WAIT}.
  - Constant SYNC_STAGES=2.
- Sub-module sync_2ff (CLK, n_res, d, q): plain 2-flop synchroniser with async active-low reset. It is reused by later blocks.
- The FSM and counter live in debounce_sync.

Test Plan:
- Reset: n_res=0 for 15ps with din=1 -> Q=0, rise=0, fall=0, busy=0 immediately, independent of CLK.
- Clean rise: after reset, CLK period 100ps, din 0->1 held for 8 cycles -> Q=1 on the 5th posedge after din rises. rise=1 for exactly that cycle. busy high for the preceding 3 cycles.
- Glitch rejection: din=1 for 2 cycles then 0 -> Q stays 0, rise never asserts, busy asserts then clears.
- Bounce: din pattern 1,0,1,1,1,1 (one value per cycle) -> Q rises 5 edges after the second 1, not after the first.
- Clean fall: from Q=1, din 1->0 held -> Q=0 on the 5th posedge, fall=1 for one cycle, rise stays 0.
- Reset mid-operation: Q=1 and in S_FALL_WAIT, pulse n_res low for 15ps between edges -> Q=0 immediately, no fall pulse, state S_LOW. After release with din=0, Q stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer and its synchroniser.
package debounce_pkg;

    // Number of flops in the metastability synchroniser chain.
    localparam int unsigned SYNC_STAGES = 2;

    // Debouncer FSM states: two stable levels and two qualification windows.
    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_RISE_WAIT = 2'd1,
        S_HIGH      = 2'd2,
        S_FALL_WAIT = 2'd3
    } state_t;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Plain flop-chain synchroniser for a single asynchronous bit.
module sync_2ff
    import debounce_pkg::*;
(
    input  logic CLK,
    input  logic n_res,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the chain; only the last stage is consumed.
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw input; a new level is accepted only after
// STABLE_CYCLES consecutive agreeing samples, with one-cycle rise/fall pulses.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)
(
    input  logic CLK,
    input  logic n_res,
    input  logic din,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // din only enters the FSM through the synchroniser.
    sync_2ff u_sync (
        .CLK   (CLK),
        .n_res (n_res),
        .d     (din),
        .q     (sync2)
    );

    // Qualification FSM; busy is registered alongside state so it always
    // equals "state is a WAIT state".
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            state <= S_LOW;
            cnt   <= '0;
            Q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                S_LOW: begin
                    if (sync2) begin
                        state <= S_RISE_WAIT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_RISE_WAIT: begin
                    if (!sync2) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        Q     <= 1'b1;
                        rise  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!sync2) begin
                        state <= S_FALL_WAIT;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt   <= '0;
                    end
                end
                S_FALL_WAIT: begin
                    if (sync2) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LOW;
                        cnt   <= '0;
                        Q     <= 1'b0;
                        fall  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule : debounce_sync
